// File: rtl/oscill_cfg_ctrl.sv
// Front-panel settings controller: key pulses edit working settings, snapshot offered to engine.
// Latency: pulse k -> working reg k+1 -> cfg_valid k+2; cfg_* frozen while cfg_valid waits for cfg_ready.
module oscill_cfg_ctrl #(
    parameter int TB_MAX    = 15,
    parameter int TB_DEF    = 4,
    parameter int GAIN_MAX  = 7,
    parameter int GAIN_DEF  = 2,
    parameter int TRIG_W    = 8,
    parameter int TRIG_STEP = 4,
    parameter int TRIG_DEF  = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              key1_l2h,
    input  logic              key2_l2h,
    input  logic              key3_l2h,
    input  logic              key4_l2h,
    input  logic              key5_l2h,
    output logic [1:0]        sel,
    output logic              cfg_valid,
    input  logic              cfg_ready,
    output logic [3:0]        cfg_tb,
    output logic [2:0]        cfg_gain,
    output logic [TRIG_W-1:0] cfg_trig,
    output logic              cfg_edge,
    output logic              cfg_run
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [3:0]      TB_MAX_V   = 4'(TB_MAX);
    localparam logic [2:0]      GAIN_MAX_V = 3'(GAIN_MAX);
    localparam logic [TRIG_W:0] TRIG_TOP_X = {1'b0, {TRIG_W{1'b1}}};
    localparam logic [TRIG_W:0] STEP_X     = (TRIG_W+1)'(TRIG_STEP);

    state_t            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [3:0]        tb_q, tb_d;
    logic [2:0]        gain_q, gain_d;
    logic [TRIG_W-1:0] trig_q, trig_d;
    logic              edge_q, edge_d;
    logic              run_q, run_d;
    logic              dirty_q, dirty_d;
    logic              chg;
    logic              load;
    logic              valid_d;
    logic [TRIG_W:0]   trig_up, trig_dn;

    assign sel     = sel_q;
    assign trig_up = {1'b0, trig_q} + STEP_X;
    assign trig_dn = {1'b0, trig_q} - STEP_X;

    // Key decode: key4 > key1 > key2 > key3, lock gates keys 1-3 only
    always_comb begin
        sel_d  = sel_q;
        tb_d   = tb_q;
        gain_d = gain_q;
        trig_d = trig_q;
        edge_d = edge_q;
        run_d  = run_q;
        if (key4_l2h) begin
            run_d = ~run_q;
        end else if (!key5_l2h) begin
            if (key1_l2h) begin
                sel_d = sel_q + 2'd1;
            end else if (key2_l2h || key3_l2h) begin
                case (sel_q)
                    2'd0: begin
                        if (key2_l2h) begin
                            if (tb_q != TB_MAX_V) tb_d = tb_q + 4'd1;
                        end else if (tb_q != 4'd0) begin
                            tb_d = tb_q - 4'd1;
                        end
                    end
                    2'd1: begin
                        if (key2_l2h) begin
                            if (gain_q != GAIN_MAX_V) gain_d = gain_q + 3'd1;
                        end else if (gain_q != 3'd0) begin
                            gain_d = gain_q - 3'd1;
                        end
                    end
                    2'd2: begin
                        if (key2_l2h) begin
                            trig_d = (trig_up > TRIG_TOP_X) ? {TRIG_W{1'b1}} : trig_up[TRIG_W-1:0];
                        end else begin
                            // borrow out of the extra bit means we went below zero
                            trig_d = trig_dn[TRIG_W] ? {TRIG_W{1'b0}} : trig_dn[TRIG_W-1:0];
                        end
                    end
                    default: edge_d = ~edge_q;
                endcase
            end
        end
        chg = (tb_d != tb_q) || (gain_d != gain_q) || (trig_d != trig_q) ||
              (edge_d != edge_q) || (run_d != run_q);
    end

    // Snapshot handshake; a change landing on the load edge keeps dirty set
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        valid_d = cfg_valid;
        case (state_q)
            S_IDLE: begin
                if (dirty_q) begin
                    load    = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            default: begin
                if (cfg_valid && cfg_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
        dirty_d = chg ? 1'b1 : (load ? 1'b0 : dirty_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q   <= 2'd0;
            tb_q    <= 4'(TB_DEF);
            gain_q  <= 3'(GAIN_DEF);
            trig_q  <= TRIG_W'(TRIG_DEF);
            edge_q  <= 1'b0;
            run_q   <= 1'b1;
            dirty_q <= 1'b1;
        end else begin
            sel_q   <= sel_d;
            tb_q    <= tb_d;
            gain_q  <= gain_d;
            trig_q  <= trig_d;
            edge_q  <= edge_d;
            run_q   <= run_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_valid <= 1'b0;
            cfg_tb    <= 4'd0;
            cfg_gain  <= 3'd0;
            cfg_trig  <= {TRIG_W{1'b0}};
            cfg_edge  <= 1'b0;
            cfg_run   <= 1'b0;
        end else begin
            cfg_valid <= valid_d;
            if (load) begin
                cfg_tb   <= tb_q;
                cfg_gain <= gain_q;
                cfg_trig <= trig_q;
                cfg_edge <= edge_q;
                cfg_run  <= run_q;
            end
        end
    end

endmodule

// File: tb/tb_oscill_cfg_ctrl.sv
// Directed bench for oscill_cfg_ctrl: key sequences with hand-computed snapshots and transfer counts.
module tb_oscill_cfg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       key1_l2h, key2_l2h, key3_l2h, key4_l2h, key5_l2h;
    logic [1:0] sel;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_tb;
    logic [2:0] cfg_gain;
    logic [7:0] cfg_trig;
    logic       cfg_edge;
    logic       cfg_run;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;
    int n_ref;

    oscill_cfg_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key1_l2h  (key1_l2h),
        .key2_l2h  (key2_l2h),
        .key3_l2h  (key3_l2h),
        .key4_l2h  (key4_l2h),
        .key5_l2h  (key5_l2h),
        .sel       (sel),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_tb    (cfg_tb),
        .cfg_gain  (cfg_gain),
        .cfg_trig  (cfg_trig),
        .cfg_edge  (cfg_edge),
        .cfg_run   (cfg_run)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && cfg_valid && cfg_ready) xfers <= xfers + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic pulse(input int k);
        case (k)
            1: key1_l2h = 1'b1;
            2: key2_l2h = 1'b1;
            3: key3_l2h = 1'b1;
            default: key4_l2h = 1'b1;
        endcase
        @(negedge clk);
        key1_l2h = 1'b0;
        key2_l2h = 1'b0;
        key3_l2h = 1'b0;
        key4_l2h = 1'b0;
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        {key1_l2h, key2_l2h, key3_l2h, key4_l2h, key5_l2h} = '0;
        cfg_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vld", cfg_valid, 0);
        chk("rst_tb", cfg_tb, 0);
        chk("rst_gain", cfg_gain, 0);
        chk("rst_trig", cfg_trig, 0);
        chk("rst_run", cfg_run, 0);
        chk("rst_sel", sel, 0);

        // first transfer carries defaults
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_vld", cfg_valid, 1);
        chk("first_tb", cfg_tb, 4);
        chk("first_gain", cfg_gain, 2);
        chk("first_trig", cfg_trig, 128);
        chk("first_edge", cfg_edge, 0);
        chk("first_run", cfg_run, 1);
        cfg_ready = 1'b1;
        @(negedge clk);
        chk("first_acc", cfg_valid, 0);
        n_ref = xfers;
        repeat (3) @(negedge clk);
        chk("idle_vld", cfg_valid, 0);
        chk("idle_xfers", xfers, n_ref);

        // sel to trig, three increments each give one transfer
        pulse(1);
        chk("sel1", sel, 1);
        pulse(1);
        chk("sel2", sel, 2);
        @(negedge clk);
        chk("sel_no_vld", cfg_valid, 0);
        chk("sel_no_xfer", xfers, n_ref);
        for (int i = 1; i <= 3; i++) begin
            pulse(2);
            chk("trig_k1_vld", cfg_valid, 0);
            @(negedge clk);
            chk("trig_k2_vld", cfg_valid, 1);
            chk("trig_val", cfg_trig, 128 + 4 * i);
            @(negedge clk);
            chk("trig_acc", cfg_valid, 0);
        end

        // trig saturation high and low
        repeat (30) pulse(2);
        drain();
        chk("trig_max", cfg_trig, 255);
        n_ref = xfers;
        pulse(2);
        drain();
        chk("trig_max_noop", xfers, n_ref);
        repeat (64) pulse(3);
        drain();
        chk("trig_min", cfg_trig, 0);
        n_ref = xfers;
        pulse(3);
        drain();
        chk("trig_min_noop", xfers, n_ref);

        // edge toggles with either key
        pulse(1);
        pulse(2);
        drain();
        chk("edge_set", cfg_edge, 1);
        pulse(3);
        drain();
        chk("edge_clr", cfg_edge, 0);
        pulse(1);
        chk("sel_wrap", sel, 0);

        // timebase saturates at 15
        repeat (11) pulse(2);
        drain();
        chk("tb_max", cfg_tb, 15);
        n_ref = xfers;
        repeat (4) pulse(2);
        drain();
        chk("tb_max_hold", cfg_tb, 15);
        chk("tb_max_noxfer", xfers, n_ref);
        n_ref = xfers;
        repeat (4) pulse(1);
        drain();
        chk("sel_wrap4", sel, 0);
        chk("sel_wrap_noxfer", xfers, n_ref);

        // backpressure: changes during WAIT coalesce
        pulse(1);
        cfg_ready = 1'b0;
        n_ref = xfers;
        pulse(4);
        @(negedge clk);
        chk("bp_vld", cfg_valid, 1);
        chk("bp_run", cfg_run, 0);
        chk("bp_gain", cfg_gain, 2);
        pulse(2);
        repeat (2) @(negedge clk);
        chk("bp_hold_vld", cfg_valid, 1);
        chk("bp_hold_gain", cfg_gain, 2);
        cfg_ready = 1'b1;
        @(negedge clk);
        chk("bp_gap", cfg_valid, 0);
        @(negedge clk);
        chk("bp_re_vld", cfg_valid, 1);
        chk("bp_re_gain", cfg_gain, 3);
        chk("bp_re_run", cfg_run, 0);
        repeat (4) @(negedge clk);
        chk("bp_xfers", xfers - n_ref, 2);

        // panel lock
        key5_l2h = 1'b1;
        n_ref = xfers;
        pulse(1);
        pulse(2);
        pulse(3);
        drain();
        chk("lock_sel", sel, 1);
        chk("lock_gain", cfg_gain, 3);
        chk("lock_xfer", xfers, n_ref);
        pulse(4);
        @(negedge clk);
        chk("lock_k4_vld", cfg_valid, 1);
        chk("lock_k4_run", cfg_run, 1);
        key5_l2h = 1'b0;
        @(negedge clk);

        // key4 beats key2, then reset mid-WAIT
        cfg_ready = 1'b0;
        key4_l2h = 1'b1;
        key2_l2h = 1'b1;
        @(negedge clk);
        key4_l2h = 1'b0;
        key2_l2h = 1'b0;
        @(negedge clk);
        chk("prio_vld", cfg_valid, 1);
        chk("prio_run", cfg_run, 0);
        chk("prio_gain", cfg_gain, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_vld", cfg_valid, 0);
        chk("arst_tb", cfg_tb, 0);
        chk("arst_sel", sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_vld", cfg_valid, 1);
        chk("post_tb", cfg_tb, 4);
        chk("post_gain", cfg_gain, 2);
        chk("post_trig", cfg_trig, 128);
        chk("post_run", cfg_run, 1);
        cfg_ready = 1'b1;
        @(negedge clk);
        chk("post_acc", cfg_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
